ram_scan_resp: RTL and testbench
================================

# ram_scan_resp

Byte-wide data-memory responder for the TINYCPU RAM bus: it answers the CPU's active-low read/write strobes on the `ram_addr`/`ram_wdat`/`ram_rdat` interface. It also watches a fixed display window of memory (default bytes 0..31). Whenever the CPU writes inside that window, it streams the whole window out on a valid/ready scan port, so a console or monitor can show memory as text. It sits opposite the CPU on the RAM bus and replaces the bare RAM model.

## Interface
Parameters:
- `WIN_BASE`, default 0: first address of the display window.
- `WIN_LEN`, default 32: number of bytes in the window. Range 1..256, with `WIN_BASE+WIN_LEN` ≤ 256.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ram_addr`  in  8  byte address from the CPU.
- `ram_wdat`  in  8  write data from the CPU.
- `ram_rdat`  out  8  read data to the CPU.
- `ram_rd_`  in  1  read strobe, active-low.
- `ram_wr_`  in  1  write strobe, active-low.
- `scan_valid`  out  1  scan byte present.
- `scan_ready`  in  1  consumer accepts the byte.
- `scan_data`  out  8  window byte being presented.
- `scan_idx`  out  8  offset of `scan_data` within the window (0..WIN_LEN-1).
- `scan_last`  out  1  high together with `scan_valid` on offset WIN_LEN-1.

## Operation
- Storage: `mem[0:255]`, 8 bits per entry. Reset does not clear it; initial contents come from `$readmemh` by hierarchical access to `mem`.
- Write: at a rising `clk` edge with `ram_wr_`=0, `mem[ram_addr] <= ram_wdat`.
- Read:
  - Combinational: `ram_rdat = mem[ram_addr]` while `ram_rd_`=0.
  - `ram_rdat = 8'h00` while `ram_rd_`=1.
- Read and write in the same cycle: `ram_rdat` shows the pre-write value; the write lands at the edge.
- Dirty flag:
  - Set at a write edge when `WIN_BASE` ≤ `ram_addr` < `WIN_BASE+WIN_LEN`.
  - Cleared on the IDLE→LOAD transition.
  - If a set and a clear fall on the same edge, set wins.
- Scan FSM (states IDLE, LOAD, SEND):
  - IDLE: `scan_valid`=0. If dirty: clear dirty, `idx`←0, go to LOAD.
  - LOAD: `scan_data` ← `mem[WIN_BASE+idx]`, with the value read before any same-edge write. `scan_idx`←`idx`, `scan_last`←(`idx`==WIN_LEN-1). Go to SEND.
  - SEND: `scan_valid`=1. `scan_data`, `scan_idx` and `scan_last` stay stable until accepted.
    - On `scan_ready`=1 with `scan_last`=1: go to IDLE.
    - On `scan_ready`=1 otherwise: `idx`←`idx`+1, go to LOAD.
    - With `scan_ready`=0: hold.
- Writes into the window during a scan re-set dirty. When the current scan finishes, a complete new scan follows from offset 0. A scan is never restarted mid-stream.
- Writes outside the window never start a scan.

## Timing
- Reset values:
  - Outputs: `scan_valid`=0, `scan_data`=0, `scan_idx`=0, `scan_last`=0. `ram_rdat` follows the combinational rule.
  - Internal: state IDLE, dirty=0, `idx`=0.
- Reset asserted mid-scan: the scan aborts immediately and a pending dirty flag is discarded. After release the FSM waits in IDLE for a new window write.
- Latency: window write at edge N → dirty at N → LOAD at N+1 → `scan_valid`=1 after edge N+2.
- Throughput: one byte per 2 cycles with `scan_ready` held at 1. A full default scan takes 64 cycles.
- Handshake: a byte transfers at a rising edge where `scan_valid`=1 and `scan_ready`=1. `scan_ready` may be asserted before `scan_valid`.
- Index arithmetic: `WIN_BASE+idx` is 8-bit and never wraps given the parameter constraint.

## Configuration
- `RAM_SCAN_EN` defined:
  - Dirty tracking, the scan FSM and the scan outputs are compiled in as described above.
- `RAM_SCAN_EN` undefined:
  - The block is a plain responder (storage, write and read only).
  - `scan_valid`, `scan_data`, `scan_idx` and `scan_last` are tied to 0; `scan_ready` is ignored.
  - No dirty flag or FSM registers exist.

## Test plan
- Write/read: write 8'h41 to addr 8'h05, then `ram_rd_`=0 at addr 5 → `ram_rdat`=8'h41. With `ram_rd_`=1 → `ram_rdat`=8'h00.
- Same-cycle read/write: `mem[7]`=8'h10; in one cycle `ram_rd_`=0, `ram_wr_`=0, `ram_wdat`=8'h20 → `ram_rdat`=8'h10 in that cycle and 8'h20 the next.
- Scan on window write: preload the window with 'A'..; write 'H' to addr 0 with `scan_ready`=1 → `scan_valid` rises 2 cycles after the write edge. Exactly 32 transfers occur, `scan_idx` runs 0..31, byte 0 is 'H', and `scan_last` is high only on idx 31.
- Backpressure: hold `scan_ready`=0 for 10 cycles on idx 3 → `scan_data` and `scan_idx` stay stable, with no skipped or duplicated index.
- Rescan and outside-window writes:
  - A write to addr 8'h40 → no scan.
  - A write to addr 2 during a scan at idx 10 → that scan completes to idx 31, then a second full scan shows the new byte at idx 2.
- Reset mid-scan: assert `rst` at idx 5 → `scan_valid`=0 immediately. No scan follows release until the next window write.
- Macro off: build without `RAM_SCAN_EN` and write to addr 0 → scan outputs stay 0 while read/write still work.

Source files
------------

// File: rtl/ram_scan_resp.sv
// Byte-wide RAM responder for the TINYCPU bus with an optional display-window scan port.
// The scan port, dirty tracking and scan FSM are compiled in only when RAM_SCAN_EN is defined.
module ram_scan_resp #(
    parameter int WIN_BASE = 0,
    parameter int WIN_LEN  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ram_addr,
    input  logic [7:0] ram_wdat,
    output logic [7:0] ram_rdat,
    input  logic       ram_rd_,
    input  logic       ram_wr_,
    output logic       scan_valid,
    input  logic       scan_ready,
    output logic [7:0] scan_data,
    output logic [7:0] scan_idx,
    output logic       scan_last
);

    // Memory is deliberately left out of reset so preloaded contents survive it.
    logic [7:0] mem [0:255];

    always_ff @(posedge clk) begin
        if (!ram_wr_) begin
            mem[ram_addr] <= ram_wdat;
        end
    end

    assign ram_rdat = ram_rd_ ? 8'h00 : mem[ram_addr];

`ifdef RAM_SCAN_EN
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t     state, state_nxt;
    logic       dirty, dirty_clr, win_hit, load;
    logic [7:0] idx, idx_nxt;
    logic [9:0] rel_addr;

    // Addresses below the window wrap to a large offset, so one compare covers both bounds.
    assign rel_addr = {2'b00, ram_addr} - 10'(WIN_BASE);
    assign win_hit  = !ram_wr_ && (rel_addr < 10'(WIN_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dirty     <= 1'b0;
            idx       <= 8'd0;
            scan_data <= 8'd0;
            scan_idx  <= 8'd0;
            scan_last <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (win_hit) begin
                dirty <= 1'b1;
            end else if (dirty_clr) begin
                dirty <= 1'b0;
            end
            if (load) begin
                scan_data <= mem[8'(WIN_BASE) + idx];
                scan_idx  <= idx;
                scan_last <= (idx == 8'(WIN_LEN - 1));
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        dirty_clr  = 1'b0;
        load       = 1'b0;
        scan_valid = 1'b0;
        case (state)
            IDLE: begin
                if (dirty) begin
                    dirty_clr = 1'b1;
                    idx_nxt   = 8'd0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                load      = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                scan_valid = 1'b1;
                if (scan_ready) begin
                    if (scan_last) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = idx + 8'd1;
                        state_nxt = LOAD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
`else
    logic unused_scan_inputs;

    assign unused_scan_inputs = scan_ready | rst;
    assign scan_valid = 1'b0;
    assign scan_data  = 8'd0;
    assign scan_idx   = 8'd0;
    assign scan_last  = 1'b0;
`endif

endmodule

// File: tb/tb_ram_scan_resp.sv
// Directed bench for ram_scan_resp; exercises the scan port when RAM_SCAN_EN is defined,
// otherwise checks that the plain responder keeps its scan outputs at zero.
module tb_ram_scan_resp;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ram_addr, ram_wdat, ram_rdat;
    logic       ram_rd_, ram_wr_;
    logic       scan_valid, scan_ready, scan_last;
    logic [7:0] scan_data, scan_idx;

    int errors = 0;
    int checks = 0;

    logic [7:0] model    [0:255];
    logic [7:0] exp_win  [0:31];
    logic [7:0] got_idx  [0:63];
    logic [7:0] got_data [0:63];
    logic       got_last [0:63];
    int         got_n;

    always #5 clk = ~clk;

    ram_scan_resp dut (
        .clk        (clk),
        .rst        (rst),
        .ram_addr   (ram_addr),
        .ram_wdat   (ram_wdat),
        .ram_rdat   (ram_rdat),
        .ram_rd_    (ram_rd_),
        .ram_wr_    (ram_wr_),
        .scan_valid (scan_valid),
        .scan_ready (scan_ready),
        .scan_data  (scan_data),
        .scan_idx   (scan_idx),
        .scan_last  (scan_last)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input logic rd, input logic wr);
        @(negedge clk);
        ram_addr = a;
        ram_wdat = d;
        ram_rd_  = rd;
        ram_wr_  = wr;
    endtask

    task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
        applyStimulus(a, d, 1'b1, 1'b0);
        model[a] = d;
        @(negedge clk);
        ram_wr_ = 1'b1;
    endtask

    task automatic snapshot();
        for (int i = 0; i < 32; i++) exp_win[i] = model[i];
    endtask

    task automatic wait_idle(input string tag);
        int low = 0;
        for (int c = 0; c < 600 && low < 4; c++) begin
            @(negedge clk);
            low = scan_valid ? 0 : low + 1;
        end
        checkOutput(tag, 32'(low >= 4), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        for (int c = 0; c < 20 && !scan_valid; c++) @(negedge clk);
        checkOutput(tag, 32'(scan_valid), 32'd1);
    endtask

    // Enters on a negedge with scan_valid high; records every transfer of one full scan.
    task automatic collect_scan(input int hold_idx, input int hold_cyc, input int wr_idx,
                                input logic [7:0] wr_addr, input logic [7:0] wr_data);
        bit done = 0, held = 0, wrote = 0;
        logic [7:0] d0, i0;
        got_n = 0;
        scan_ready = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            ram_wr_ = 1'b1;
            if (scan_valid) begin
                if (!held && hold_cyc > 0 && int'(scan_idx) == hold_idx) begin
                    held = 1;
                    scan_ready = 1'b0;
                    d0 = scan_data;
                    i0 = scan_idx;
                    for (int h = 0; h < hold_cyc; h++) begin
                        @(negedge clk);
                        checkOutput("bp_valid", 32'(scan_valid), 32'd1);
                        checkOutput("bp_data", 32'(scan_data), 32'(d0));
                        checkOutput("bp_idx", 32'(scan_idx), 32'(i0));
                    end
                    scan_ready = 1'b1;
                end
                if (got_n < 64) begin
                    got_idx[got_n]  = scan_idx;
                    got_data[got_n] = scan_data;
                    got_last[got_n] = scan_last;
                    got_n++;
                end
                if (!wrote && wr_idx >= 0 && int'(scan_idx) == wr_idx) begin
                    wrote    = 1;
                    ram_addr = wr_addr;
                    ram_wdat = wr_data;
                    ram_wr_  = 1'b0;
                end
                if (scan_last) done = 1;
            end
            if (!done) @(negedge clk);
        end
        checkOutput("scan_done", 32'(done), 32'd1);
    endtask

    task automatic verify_scan();
        checkOutput("scan_count", 32'(got_n), 32'd32);
        for (int i = 0; i < 32 && i < got_n; i++) begin
            checkOutput("scan_idx", 32'(got_idx[i]), 32'(i));
            checkOutput("scan_data", 32'(got_data[i]), 32'(exp_win[i]));
            checkOutput("scan_last", 32'(got_last[i]), 32'(i == 31));
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen, seen_d, seen_i, seen_l, found;

        rst        = 1'b1;
        ram_addr   = 8'd0;
        ram_wdat   = 8'd0;
        ram_rd_    = 1'b1;
        ram_wr_    = 1'b1;
        scan_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 32'(scan_valid), 32'd0);
        checkOutput("rst_data", 32'(scan_data), 32'd0);
        checkOutput("rst_idx", 32'(scan_idx), 32'd0);
        checkOutput("rst_last", 32'(scan_last), 32'd0);
        checkOutput("rst_rdat", 32'(ram_rdat), 32'd0);
        rst = 1'b0;
        scan_ready = 1'b1;

        write_byte(8'h05, 8'h41);
        applyStimulus(8'h05, 8'h00, 1'b0, 1'b1);
        #1 checkOutput("rd_addr5", 32'(ram_rdat), 32'h41);
        applyStimulus(8'h05, 8'h00, 1'b1, 1'b1);
        #1 checkOutput("rd_idle", 32'(ram_rdat), 32'h00);

        write_byte(8'h07, 8'h10);
        applyStimulus(8'h07, 8'h20, 1'b0, 1'b0);
        model[7] = 8'h20;
        #1 checkOutput("rw_same_old", 32'(ram_rdat), 32'h10);
        applyStimulus(8'h07, 8'h00, 1'b0, 1'b1);
        #1 checkOutput("rw_same_new", 32'(ram_rdat), 32'h20);
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);

`ifdef RAM_SCAN_EN
        for (int i = 0; i < 32; i++) write_byte(8'(i), 8'h41 + 8'(i));
        wait_idle("drain_preload");

        write_byte(8'h40, 8'h99);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen |= scan_valid;
        end
        checkOutput("outside_noscan", 32'(seen), 32'd0);
        applyStimulus(8'h40, 8'h00, 1'b0, 1'b1);
        #1 checkOutput("rd_addr40", 32'(ram_rdat), 32'h99);
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);

        applyStimulus(8'h00, 8'h48, 1'b1, 1'b0);
        model[0] = 8'h48;
        snapshot();
        @(negedge clk);
        ram_wr_ = 1'b1;
        checkOutput("lat_n0", 32'(scan_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_n1", 32'(scan_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_n2", 32'(scan_valid), 32'd1);
        collect_scan(3, 10, -1, 8'h00, 8'h00);
        verify_scan();
        wait_idle("drain_scan1");

        write_byte(8'd31, 8'h60);
        snapshot();
        wait_valid("rescan_start");
        collect_scan(-1, 0, 10, 8'h02, 8'h5A);
        verify_scan();
        model[2] = 8'h5A;
        snapshot();
        wait_valid("rescan_second");
        collect_scan(-1, 0, -1, 8'h00, 8'h00);
        verify_scan();
        wait_idle("drain_rescan");

        write_byte(8'h04, 8'h34);
        wait_valid("rstmid_start");
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (scan_valid && scan_idx == 8'd5) found = 1;
            else @(negedge clk);
        end
        checkOutput("rstmid_reach5", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_valid", 32'(scan_valid), 32'd0);
        checkOutput("rstmid_idx", 32'(scan_idx), 32'd0);
        checkOutput("rstmid_data", 32'(scan_data), 32'd0);
        checkOutput("rstmid_last", 32'(scan_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen |= scan_valid;
        end
        checkOutput("rstmid_noscan", 32'(seen), 32'd0);
        write_byte(8'h03, 8'h33);
        checkOutput("post_rst_n0", 32'(scan_valid), 32'd0);
        @(negedge clk);
        checkOutput("post_rst_n1", 32'(scan_valid), 32'd0);
        @(negedge clk);
        checkOutput("post_rst_n2", 32'(scan_valid), 32'd1);
        wait_idle("drain_final");
`else
        write_byte(8'h00, 8'h48);
        seen = 0; seen_d = 0; seen_i = 0; seen_l = 0;
        repeat (10) begin
            @(negedge clk);
            seen   |= scan_valid;
            seen_d |= (scan_data != 8'd0);
            seen_i |= (scan_idx != 8'd0);
            seen_l |= scan_last;
        end
        checkOutput("off_valid", 32'(seen), 32'd0);
        checkOutput("off_data", 32'(seen_d), 32'd0);
        checkOutput("off_idx", 32'(seen_i), 32'd0);
        checkOutput("off_last", 32'(seen_l), 32'd0);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b1);
        #1 checkOutput("off_rd_addr0", 32'(ram_rdat), 32'h48);
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
